sata_align_inserter: RTL

//  TX link-to-PHY stage, directly downstream of the CONT inserter.
//  - Inserts a burst of ALIGN primitives into the outgoing dword stream at a fixed period.
//  - Stalls the upstream stream while the burst is sent.
//  - Drives the PHY encoder, which consumes one dword per o_ready cycle.

---
 rtl/sata_align_inserter_pkg.sv | 28 ++
 rtl/sata_align_inserter_if.sv | 26 ++
 rtl/sata_align_inserter.sv | 98 +++++++++
 3 files changed

// File: rtl/sata_align_inserter_pkg.sv
// Shared constants and the dword payload type for the ALIGN inserter.
package sata_align_inserter_pkg;

    localparam int unsigned DWORD_W = 32;

    // ALIGN primitive: K28.5 D10.2 D10.2 D27.3
    localparam logic [DWORD_W-1:0] ALIGN_PRIM = 32'h7B4A4ABC;

    localparam logic DWORD_IS_PRIM = 1'b1;
    localparam logic DWORD_IS_DATA = 1'b0;

    localparam int unsigned ALIGN_PERIOD_DEF = 254;
    localparam int unsigned ALIGN_COUNT_DEF  = 2;

    typedef struct packed {
        logic               k;
        logic [DWORD_W-1:0] data;
    } dword_t;

    // The dword emitted for every inserted ALIGN slot
    function automatic dword_t align_dword();
        dword_t d;
        d.k    = DWORD_IS_PRIM;
        d.data = ALIGN_PRIM;
        return d;
    endfunction

endpackage

// File: rtl/sata_align_inserter_if.sv
// Upstream stream, PHY-side stream and control of the ALIGN inserter.
interface sata_align_inserter_if;
    import sata_align_inserter_pkg::*;

    logic               align_ena;
    logic [DWORD_W-1:0] i_data;
    logic               i_datak;
    logic               i_ready;
    logic [DWORD_W-1:0] o_data;
    logic               o_datak;
    logic               o_ready;
    logic               o_align;

    // Environment side: CONT inserter upstream plus PHY downstream
    modport master (
        output align_ena, i_data, i_datak, o_ready,
        input  i_ready, o_data, o_datak, o_align
    );

    // Inserter side
    modport slave (
        input  align_ena, i_data, i_datak, o_ready,
        output i_ready, o_data, o_datak, o_align
    );

endinterface

// File: rtl/sata_align_inserter.sv
// TX link-to-PHY stage: inserts periodic ALIGN bursts, stalling upstream meanwhile.
module sata_align_inserter
    import sata_align_inserter_pkg::*;
#(
    parameter int unsigned ALIGN_PERIOD = ALIGN_PERIOD_DEF,
    parameter int unsigned ALIGN_COUNT  = ALIGN_COUNT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sata_align_inserter_if.slave  bus
);

    localparam int unsigned PCNT_W = $clog2(ALIGN_PERIOD + 1);
    localparam int unsigned ACNT_W = $clog2(ALIGN_COUNT + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(ALIGN_PERIOD - 1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALIGN_COUNT - 1);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_ALIGN = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [ACNT_W-1:0]   acnt_q, acnt_d;
    dword_t              out_dword;

    // Next state and counters; everything holds while the PHY is not taking a dword
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        acnt_d  = acnt_q;
        if (bus.o_ready) begin
            unique case (state_q)
                ST_PASS: begin
                    if (!bus.align_ena) begin
                        pcnt_d = '0;
                    end else if (pcnt_q == PCNT_LAST) begin
                        state_d = ST_ALIGN;
                        pcnt_d  = '0;
                        acnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
                ST_ALIGN: begin
                    // A burst always runs to completion regardless of align_ena
                    if (acnt_q == ACNT_LAST) begin
                        state_d = ST_PASS;
                        pcnt_d  = '0;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + ACNT_W'(1);
                    end
                end
                default: state_d = ST_ALIGN;
            endcase
        end
    end

    // State and counter registers; reset opens the link with a full burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ALIGN;
            pcnt_q  <= '0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            acnt_q  <= acnt_d;
        end
    end

    // Zero-latency output mux: ALIGN in a burst, otherwise straight pass-through
    always_comb begin
        out_dword.k    = bus.i_datak;
        out_dword.data = bus.i_data;
        if (state_q == ST_ALIGN) begin
            out_dword = align_dword();
        end
    end

    assign bus.o_data  = out_dword.data;
    assign bus.o_datak = out_dword.k;
    assign bus.o_align = (state_q == ST_ALIGN);
    assign bus.i_ready = (state_q == ST_PASS) && bus.o_ready;

    // Parameter sanity
    a_params: assert property (@(posedge clk) (ALIGN_PERIOD >= 1) && (ALIGN_COUNT >= 1))
        else $error("sata_align_inserter: ALIGN_PERIOD and ALIGN_COUNT must be >= 1");

    // Upstream is never accepted while a burst is on the wire
    a_no_accept_in_align: assert property (@(posedge clk) disable iff (reset)
        !((state_q == ST_ALIGN) && bus.i_ready))
        else $error("sata_align_inserter: i_ready high during ALIGN");

endmodule
